// File: rtl/inst_cache_pkg.sv
// Shared constants for the instruction cache: truth levels, default geometry
// and FSM state encodings.
package inst_cache_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;
   localparam logic HIGH  = 1'b1;
   localparam logic LOW   = 1'b0;

   localparam int DEF_INDEX_BITS  = 7;
   localparam int DEF_OFFSET_BITS = 4;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] FILL = 1'b1;

endpackage

// File: rtl/inst_cache_array.sv
// Valid/tag/data storage: combinational read by index, synchronous word write.
// Tag and valid are committed together with the last word of a block.
module icache_array #(
   parameter int INDEX_BITS = 7,
   parameter int WORD_BITS  = 2,
   parameter int TAG_BITS   = 21
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_index,
   input  logic [WORD_BITS-1:0]  rd_woff,
   output logic                  rd_valid,
   output logic [TAG_BITS-1:0]   rd_tag,
   output logic [31:0]           rd_word,
   input  logic                  wr_en,
   input  logic                  wr_last,
   input  logic [INDEX_BITS-1:0] wr_index,
   input  logic [WORD_BITS-1:0]  wr_woff,
   input  logic [TAG_BITS-1:0]   wr_tag,
   input  logic [31:0]           wr_data
);
   import inst_cache_pkg::*;

   localparam int LINES = 1 << INDEX_BITS;
   localparam int WORDS = 1 << (INDEX_BITS + WORD_BITS);

   logic [LINES-1:0]    valid_q;
   logic [LINES-1:0]    valid_d;
   logic [TAG_BITS-1:0] tag_q  [LINES];
   logic [31:0]         data_q [WORDS];

   always_comb begin
      valid_d = valid_q;
      if (wr_en && wr_last) begin
         valid_d[wr_index] = TRUE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data carry no reset: they are meaningless until valid is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_q[{wr_index, wr_woff}] <= wr_data;
      end
      if (wr_en && wr_last) begin
         tag_q[wr_index] <= wr_tag;
      end
   end

   assign rd_valid = valid_q[rd_index];
   assign rd_tag   = tag_q[rd_index];
   assign rd_word  = data_q[{rd_index, rd_woff}];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only I-cache: 1-cycle hit pulse, in-order block refill on miss.
// rdy low freezes everything; clear drops responses but lets a refill finish.
module inst_cache #(
   parameter int INDEX_BITS  = inst_cache_pkg::DEF_INDEX_BITS,
   parameter int OFFSET_BITS = inst_cache_pkg::DEF_OFFSET_BITS
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        clear,
   input  logic        pc_valid,
   input  logic [31:0] pc,
   output logic        inst_ready,
   output logic [31:0] inst,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_word_ready,
   input  logic [31:0] mem_word
);
   import inst_cache_pkg::*;

   localparam int TAG_BITS  = 32 - INDEX_BITS - OFFSET_BITS;
   localparam int WORD_BITS = OFFSET_BITS - 2;
   localparam logic [WORD_BITS-1:0] LAST_WORD = {WORD_BITS{1'b1}};

   logic [0:0]           state_q, state_d;
   logic [WORD_BITS-1:0] cnt_q, cnt_d;
   logic                 cool_q, cool_d;
   logic                 inst_ready_q, inst_ready_d;
   logic [31:0]          inst_q, inst_d;
   logic                 mem_req_q, mem_req_d;
   logic [31:0]          mem_addr_q, mem_addr_d;

   logic                rd_valid;
   logic [TAG_BITS-1:0] rd_tag;
   logic [31:0]         rd_word;
   logic                hit;
   logic                wr_en;
   logic                wr_last;
   logic                unused_pc_lsb;

   assign unused_pc_lsb = ^pc[1:0];

   icache_array #(
      .INDEX_BITS (INDEX_BITS),
      .WORD_BITS  (WORD_BITS),
      .TAG_BITS   (TAG_BITS)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_index (pc[OFFSET_BITS +: INDEX_BITS]),
      .rd_woff  (pc[2 +: WORD_BITS]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_word  (rd_word),
      .wr_en    (wr_en),
      .wr_last  (wr_last),
      .wr_index (mem_addr_q[OFFSET_BITS +: INDEX_BITS]),
      .wr_woff  (cnt_q),
      .wr_tag   (mem_addr_q[31 -: TAG_BITS]),
      .wr_data  (mem_word)
   );

   assign hit = rd_valid && (rd_tag == pc[31 -: TAG_BITS]);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cool_d       = cool_q;
      inst_ready_d = FALSE;
      inst_d       = inst_q;
      mem_req_d    = mem_req_q;
      mem_addr_d   = mem_addr_q;
      wr_en        = FALSE;
      wr_last      = FALSE;
      if (rdy && !rst) begin
         cool_d = FALSE;
         case (state_q)
            IDLE: begin
               if (pc_valid && !cool_q && !clear) begin
                  if (hit) begin
                     inst_d       = rd_word;
                     inst_ready_d = TRUE;
                     cool_d       = TRUE;
                  end else begin
                     mem_addr_d = {pc[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                     mem_req_d  = HIGH;
                     cnt_d      = '0;
                     state_d    = FILL;
                  end
               end
            end
            FILL: begin
               // The refill always runs to completion; the next IDLE cycle re-looks up pc.
               if (mem_word_ready) begin
                  wr_en = TRUE;
                  cnt_d = cnt_q + WORD_BITS'(1);
                  if (cnt_q == LAST_WORD) begin
                     wr_last   = TRUE;
                     mem_req_d = LOW;
                     state_d   = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         cool_q       <= FALSE;
         inst_ready_q <= FALSE;
         inst_q       <= '0;
         mem_req_q    <= LOW;
         mem_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cool_q       <= cool_d;
         inst_ready_q <= inst_ready_d;
         inst_q       <= inst_d;
         mem_req_q    <= mem_req_d;
         mem_addr_q   <= mem_addr_d;
      end
   end

   assign inst_ready = inst_ready_q;
   assign inst       = inst_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: expected instructions are queued at stimulus
// time and popped by a monitor on every inst_ready pulse.
module tb_inst_cache;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        clear;
   logic        pc_valid;
   logic [31:0] pc;
   logic        inst_ready;
   logic [31:0] inst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_word_ready;
   logic [31:0] mem_word;

   int vectors = 0;
   int miscompares = 0;
   logic [31:0] exp_q [$];

   inst_cache dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .clear          (clear),
      .pc_valid       (pc_valid),
      .pc             (pc),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_word_ready (mem_word_ready),
      .mem_word       (mem_word)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every response pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (inst_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_resp: got inst 0x%08h, expected no response", inst);
         end else begin
            check("resp_inst", inst, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic request(input logic [31:0] a);
      pc       = a;
      pc_valid = 1'b1;
   endtask

   task automatic feed_word(input logic [31:0] w);
      mem_word_ready = 1'b1;
      mem_word       = w;
      step();
      mem_word_ready = 1'b0;
      mem_word       = '0;
   endtask

   task automatic expect_refill(input string name, input logic [31:0] a);
      step();
      check({name, "_req"}, {31'd0, mem_req}, 32'd1);
      check({name, "_addr"}, mem_addr, a);
   endtask

   task automatic feed_block(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
      feed_word(w0);
      feed_word(w1);
      feed_word(w2);
      feed_word(w3);
      check("fill_done_req", {31'd0, mem_req}, 32'd0);
   endtask

   // Waits for the response, then holds the request one more cycle (fetch lag).
   task automatic wait_resp(input string name);
      bit got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (inst_ready === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      check({name, "_arrived"}, {31'd0, got}, 32'd1);
      step();
      pc_valid = 1'b0;
   endtask

   task automatic expect_hit(input string name, input logic [31:0] a, input logic [31:0] w);
      request(a);
      exp_q.push_back(w);
      step();
      check({name, "_lat1"}, {31'd0, inst_ready}, 32'd1);
      check({name, "_noreq"}, {31'd0, mem_req}, 32'd0);
      step();
      check({name, "_cooldown"}, {31'd0, inst_ready}, 32'd0);
      pc_valid = 1'b0;
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; clear = 1'b0; pc_valid = 1'b0; pc = '0;
      mem_word_ready = 1'b0; mem_word = '0;
      step();
      step();
      check("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
      check("rst_inst", inst, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      rst = 1'b0;
      step();

      // Cold miss at 0x10
      request(32'h0000_0010);
      expect_refill("cold", 32'h0000_0010);
      feed_block(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      exp_q.push_back(32'hA0);
      wait_resp("cold");
      step();

      // Hit in the freshly filled block, word 3
      expect_hit("hit_w3", 32'h0000_001C, 32'hA3);

      // Stray memory word while IDLE must not disturb the array
      feed_word(32'hFFFF_FFFF);
      expect_hit("stray_word", 32'h0000_0014, 32'hA1);

      // Conflict eviction: same index, different tag
      request(32'h0000_0810);
      expect_refill("evict", 32'h0000_0810);
      feed_block(32'hB0, 32'hB1, 32'hB2, 32'hB3);
      exp_q.push_back(32'hB0);
      wait_resp("evict");
      request(32'h0000_0010);
      expect_refill("remiss", 32'h0000_0010);
      feed_block(32'hA0, 32'hA1, 32'hA2, 32'hA3);
      exp_q.push_back(32'hA0);
      wait_resp("remiss");
      step();

      // Clear mid-fill: refill completes silently, line becomes valid
      request(32'h0000_0020);
      expect_refill("clrfill", 32'h0000_0020);
      feed_word(32'hC0);
      feed_word(32'hC1);
      clear = 1'b1;
      pc_valid = 1'b0;
      step();
      clear = 1'b0;
      feed_word(32'hC2);
      feed_word(32'hC3);
      check("clrfill_done_req", {31'd0, mem_req}, 32'd0);
      repeat (3) step();
      expect_hit("clrfill_hit", 32'h0000_0024, 32'hC1);

      // rdy stall mid-fill with memory words pulsing
      request(32'h0000_0030);
      expect_refill("stall", 32'h0000_0030);
      feed_word(32'hD0);
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         feed_word(32'hDEAD_0000 + i);
         check("stall_req_hold", {31'd0, mem_req}, 32'd1);
         check("stall_addr_hold", mem_addr, 32'h0000_0030);
      end
      rdy = 1'b1;
      feed_word(32'hD1);
      feed_word(32'hD2);
      check("stall_req_before_last", {31'd0, mem_req}, 32'd1);
      feed_word(32'hD3);
      check("stall_done_req", {31'd0, mem_req}, 32'd0);
      exp_q.push_back(32'hD0);
      wait_resp("stall");
      step();
      expect_hit("stall_hit_w2", 32'h0000_0038, 32'hD2);

      // Reset mid-fill abandons the refill
      request(32'h0000_0040);
      expect_refill("rstfill", 32'h0000_0040);
      feed_word(32'hE0);
      feed_word(32'hE1);
      rst = 1'b1;
      pc_valid = 1'b0;
      step();
      check("rstfill_inst_ready", {31'd0, inst_ready}, 32'd0);
      check("rstfill_inst", inst, 32'd0);
      check("rstfill_mem_req", {31'd0, mem_req}, 32'd0);
      check("rstfill_mem_addr", mem_addr, 32'd0);
      rst = 1'b0;
      step();
      request(32'h0000_0040);
      expect_refill("rerefill", 32'h0000_0040);
      feed_block(32'hF0, 32'hF1, 32'hF2, 32'hF3);
      exp_q.push_back(32'hF0);
      wait_resp("rerefill");
      step();

      // Block 0x10 was invalidated by the reset as well
      request(32'h0000_0010);
      expect_refill("post_rst_miss", 32'h0000_0010);
      feed_block(32'h10, 32'h11, 32'h12, 32'h13);
      exp_q.push_back(32'h10);
      wait_resp("post_rst_miss");
      repeat (3) step();

      check("pending_expectations", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
